alu_op_issue: RTL and testbench

ALU_OP_ISSUE -- requirements
Module: alu_op_issue

---
 rtl/alu_op_issue.sv | 154 +++++++++++++++
 tb/tb_alu_op_issue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issue.sv
// alu_op_issue
//   Decodes one MIPS-style instruction per cycle into an ALU operation and
//   presents it through a single valid/ready output register stage.
//   Instructions with an opcode/funct combination the ALU cannot execute are
//   consumed, flagged with a one-cycle o_illegal pulse and counted in a
//   saturating 8-bit counter.
//
// Ports
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_valid / o_ready       upstream handshake
//   i_opcode, i_funct       instruction opcode and R-type function field
//   i_rs_data, i_rt_data    register operands
//   i_imm, i_shamt          immediate and shift amount
//   i_flush                 drops the held op and any concurrent input
//   o_valid / i_ready       downstream (ALU stage) handshake
//   o_alu_control_signals   ALU control code
//   o_alu_input_A/B         ALU operands
//   o_shamt                 shift amount for the ALU
//   o_illegal               one-cycle pulse after an illegal op is consumed
//   o_illegal_cnt           saturating count of illegal ops
module alu_op_issue #(
    parameter int NB_DATA    = 32,
    parameter int NB_CONTROL = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [5:0]            i_opcode,
    input  logic [5:0]            i_funct,
    input  logic [NB_DATA-1:0]    i_rs_data,
    input  logic [NB_DATA-1:0]    i_rt_data,
    input  logic [15:0]           i_imm,
    input  logic [4:0]            i_shamt,
    input  logic                  i_flush,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [NB_CONTROL-1:0] o_alu_control_signals,
    output logic [NB_DATA-1:0]    o_alu_input_A,
    output logic [NB_DATA-1:0]    o_alu_input_B,
    output logic [4:0]            o_shamt,
    output logic                  o_illegal,
    output logic [7:0]            o_illegal_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [5:0] CTL_ADD  = 6'b100000;
    localparam logic [5:0] CTL_ADDU = 6'b100001;
    localparam logic [5:0] CTL_AND  = 6'b100100;
    localparam logic [5:0] CTL_OR   = 6'b100101;
    localparam logic [5:0] CTL_XOR  = 6'b100110;
    localparam logic [5:0] CTL_SLT  = 6'b101010;
    localparam logic [5:0] CTL_SLTU = 6'b101011;
    localparam logic [5:0] CTL_LUI  = 6'b001111;

    logic               accept;
    logic               dec_legal;
    logic [5:0]         dec_code;
    logic [NB_DATA-1:0] dec_a;
    logic [NB_DATA-1:0] dec_b;
    logic [4:0]         dec_shamt;
    logic [NB_DATA-1:0] imm_sext;
    logic [NB_DATA-1:0] imm_zext;
    logic [NB_DATA-1:0] imm_upper;

    assign o_ready   = !o_valid || i_ready;
    assign accept    = i_valid && o_ready && !i_flush;

    assign imm_sext  = NB_DATA'($signed(i_imm));
    assign imm_zext  = NB_DATA'(i_imm);
    assign imm_upper = NB_DATA'({i_imm, 16'h0000});

    always_comb begin
        dec_legal = 1'b0;
        dec_code  = 6'b000000;
        dec_a     = i_rs_data;
        dec_b     = i_rt_data;
        dec_shamt = 5'd0;
        case (i_opcode)
            OP_RTYPE: begin
                // R-type passes funct straight through as the control code
                case (i_funct)
                    6'b100000, 6'b100001, 6'b100010, 6'b100011,
                    6'b100100, 6'b100101, 6'b100110, 6'b100111,
                    6'b000000, 6'b000010, 6'b000011, 6'b000100,
                    6'b000110, 6'b000111, 6'b101010, 6'b101011: begin
                        dec_legal = 1'b1;
                        dec_code  = i_funct;
                        dec_shamt = i_shamt;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_ADDI:  begin dec_legal = 1'b1; dec_code = CTL_ADD;  dec_b = imm_sext; end
            OP_ADDIU: begin dec_legal = 1'b1; dec_code = CTL_ADDU; dec_b = imm_sext; end
            OP_SLTI:  begin dec_legal = 1'b1; dec_code = CTL_SLT;  dec_b = imm_sext; end
            OP_SLTIU: begin dec_legal = 1'b1; dec_code = CTL_SLTU; dec_b = imm_sext; end
            OP_ANDI:  begin dec_legal = 1'b1; dec_code = CTL_AND;  dec_b = imm_zext; end
            OP_ORI:   begin dec_legal = 1'b1; dec_code = CTL_OR;   dec_b = imm_zext; end
            OP_XORI:  begin dec_legal = 1'b1; dec_code = CTL_XOR;  dec_b = imm_zext; end
            OP_LUI: begin
                dec_legal = 1'b1;
                dec_code  = CTL_LUI;
                dec_a     = '0;
                dec_b     = imm_upper;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid               <= 1'b0;
            o_illegal             <= 1'b0;
            o_illegal_cnt         <= 8'd0;
            o_alu_control_signals <= '0;
            o_alu_input_A         <= '0;
            o_alu_input_B         <= '0;
            o_shamt               <= 5'd0;
        end else begin
            o_illegal <= 1'b0;
            if (i_flush) begin
                o_valid <= 1'b0;
            end else if (accept && dec_legal) begin
                o_valid               <= 1'b1;
                o_alu_control_signals <= NB_CONTROL'(dec_code);
                o_alu_input_A         <= dec_a;
                o_alu_input_B         <= dec_b;
                o_shamt               <= dec_shamt;
            end else begin
                // An illegal accept implies o_ready, so any held op retires too
                if (i_ready) begin
                    o_valid <= 1'b0;
                end
                if (accept) begin
                    o_illegal <= 1'b1;
                    if (o_illegal_cnt != 8'hFF) begin
                        o_illegal_cnt <= o_illegal_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_op_issue.sv
module tb_alu_op_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld;
    logic        o_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [4:0]  shamt;
    logic        flush;
    logic        o_valid;
    logic        rdy;
    logic [5:0]  o_ctrl;
    logic [31:0] o_a;
    logic [31:0] o_b;
    logic [4:0]  o_sh;
    logic        o_illegal;
    logic [7:0]  o_illegal_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // reference state: what the issue stage should be showing
    bit          m_valid;
    bit          m_ill;
    int          m_cnt;
    logic [5:0]  m_ctrl;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [4:0]  m_sh;

    always #5 clk = ~clk;

    alu_op_issue #(.NB_DATA(32), .NB_CONTROL(6)) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_valid               (vld),
        .o_ready               (o_ready),
        .i_opcode              (opcode),
        .i_funct               (funct),
        .i_rs_data             (rs),
        .i_rt_data             (rt),
        .i_imm                 (imm),
        .i_shamt               (shamt),
        .i_flush               (flush),
        .o_valid               (o_valid),
        .i_ready               (rdy),
        .o_alu_control_signals (o_ctrl),
        .o_alu_input_A         (o_a),
        .o_alu_input_B         (o_b),
        .o_shamt               (o_sh),
        .o_illegal             (o_illegal),
        .o_illegal_cnt         (o_illegal_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Decode straight from the instruction tables
    function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                       input logic [31:0] a_in, input logic [31:0] b_in,
                                       input logic [15:0] im, input logic [4:0] sh,
                                       output bit legal, output logic [5:0] ctrl,
                                       output logic [31:0] a, output logic [31:0] b,
                                       output logic [4:0] s);
        logic [5:0] itab [8];
        int idx;
        itab = '{6'h20, 6'h21, 6'h2a, 6'h2b, 6'h24, 6'h25, 6'h26, 6'h0f};
        legal = 0; ctrl = 0; a = a_in; b = b_in; s = 0;
        if (op == 0) begin
            if (fn inside {[6'h20:6'h27], 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h2a, 6'h2b}) begin
                legal = 1; ctrl = fn; s = sh;
            end
        end else if (op >= 8 && op <= 15) begin
            idx   = int'(op) - 8;
            legal = 1;
            ctrl  = itab[idx];
            if (idx < 4)       b = 32'(int'($signed(im)));
            else if (idx < 7)  b = {16'h0000, im};
            else begin         b = {im, 16'h0000}; a = 0; end
        end
    endfunction

    task automatic cycle();
        bit          acc;
        bit          lg;
        logic [5:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  s;
        #1;
        check("o_ready", o_ready, (!m_valid || rdy));
        @(posedge clk);
        ref_decode(opcode, funct, rs, rt, imm, shamt, lg, c, a, b, s);
        acc   = vld && (!m_valid || rdy) && !flush;
        m_ill = 0;
        if (!rst_n) begin
            m_valid = 0; m_cnt = 0; m_ctrl = 0; m_a = 0; m_b = 0; m_sh = 0;
        end else if (flush) begin
            m_valid = 0;
        end else if (acc && lg) begin
            m_valid = 1; m_ctrl = c; m_a = a; m_b = b; m_sh = s;
        end else begin
            if (m_valid && rdy) m_valid = 0;
            if (acc) begin
                m_ill = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        #1;
        check("o_valid", o_valid, m_valid);
        check("o_illegal", o_illegal, m_ill);
        check("o_illegal_cnt", o_illegal_cnt, m_cnt);
        if (m_valid) begin
            check("ctrl", o_ctrl, m_ctrl);
            check("A", o_a, m_a);
            check("B", o_b, m_b);
            check("shamt", o_sh, m_sh);
        end
        if (!rst_n) begin
            check("rst_data", {o_ctrl, o_a, o_b, o_sh}, 0);
        end
    endtask

    task automatic put(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] im, input logic [4:0] sh);
        vld = 1; opcode = op; funct = fn; rs = a; rt = b; imm = im; shamt = sh;
    endtask

    initial begin
        int r;
        m_valid = 0; m_ill = 0; m_cnt = 0; m_ctrl = 0; m_a = 0; m_b = 0; m_sh = 0;
        rst_n = 0; vld = 0; flush = 0; rdy = 1;
        opcode = 0; funct = 0; rs = 0; rt = 0; imm = 0; shamt = 0;
        @(negedge clk);
        cycle();
        cycle();
        check("reset_valid", o_valid, 0);
        rst_n = 1;

        // scenario 1: ADDI sign-extends
        put(6'b001000, 6'h3f, 32'h5, 32'h1234, 16'hFFFF, 5'd7);
        cycle();
        check("s1_ctrl", o_ctrl, 6'b100000);
        check("s1_B", o_b, 32'hFFFFFFFF);
        check("s1_A", o_a, 32'h5);

        // scenario 2: ORI then LUI back to back
        put(6'b001101, 0, 32'hAAAA5555, 0, 16'h8001, 0);
        cycle();
        check("s2_ori_B", o_b, 32'h00008001);
        put(6'b001111, 0, 32'hAAAA5555, 0, 16'h1234, 0);
        cycle();
        check("s2_lui_B", o_b, 32'h12340000);
        check("s2_lui_A", o_a, 0);

        // scenario 3: SRA held through a 3-cycle stall
        put(6'b000000, 6'b000011, 32'h1, 32'h80000000, 0, 5'd4);
        cycle();
        vld = 0; rdy = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("s3_stall_ready", o_ready, 0);
            check("s3_stall_B", o_b, 32'h80000000);
        end
        rdy = 1;
        cycle();
        check("s3_retired_ready", o_ready, 1);

        // scenario 4: illegal opcode saturates the counter
        for (int i = 0; i < 258; i++) begin
            put(6'b111111, 0, 0, 0, 0, 0);
            cycle();
            check("s4_no_valid", o_valid, 0);
        end
        check("s4_cnt_sat", o_illegal_cnt, 8'hFF);

        // scenario 5: flush during stall with valid input
        rst_n = 0; vld = 0; cycle(); rst_n = 1;
        put(6'b001100, 0, 32'h3, 0, 16'h00F0, 0);
        cycle();
        rdy = 0; vld = 0;
        cycle();
        put(6'b001001, 0, 32'h9, 0, 16'h1, 0); flush = 1;
        cycle();
        check("s5_flushed", o_valid, 0);
        put(6'b111110, 0, 0, 0, 0, 0);
        cycle();
        check("s5_illegal_flushed", o_illegal_cnt, 0);
        flush = 0; rdy = 1;

        // scenario 6: reset during a stall, then immediate accept
        put(6'b000000, 6'b100010, 32'h10, 32'h3, 0, 0);
        cycle();
        rdy = 0; put(6'b001000, 0, 1, 0, 16'h2, 0);
        cycle();
        rst_n = 0;
        cycle();
        check("s6_rst_valid", o_valid, 0);
        rst_n = 1; rdy = 1;
        put(6'b001000, 0, 32'h7, 0, 16'h0003, 0);
        cycle();
        check("s6_reaccept", o_valid, 1);
        check("s6_B", o_b, 32'h3);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)      opcode = 6'd0;
            else if (r < 8) opcode = 6'($urandom_range(8, 15));
            else            opcode = 6'($urandom_range(0, 63));
            funct = 6'($urandom_range(0, 63));
            rs    = $urandom;
            rt    = $urandom;
            imm   = 16'($urandom);
            shamt = 5'($urandom);
            vld   = ($urandom_range(0, 3) != 0);
            rdy   = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 19) == 0);
            rst_n = ($urandom_range(0, 49) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
